// File: rtl/serial_cmd_sequencer.sv
// serial_cmd_sequencer: frames uart_rx bytes (SOF, OPCODE, N_DIG digits, CHK) into Polilock commands
// Ports:
//   i_clock, i_reset      clock and synchronous active-high reset
//   i_rx_data/finished    received byte and its 1-cycle strobe
//   i_cmd_ack             control unit accepts the pending command
//   o_cmd_valid/opcode    pending command, held until acknowledged
//   o_wr_en/addr/data     password buffer write port, one strobe per digit
//   o_frame_err           1-cycle pulse on checksum, opcode or timeout error
//   o_overrun             1-cycle pulse when a byte is dropped while a command is pending
//   o_db_estado           current state code for the 7-segment debug display
module serial_cmd_sequencer #(
  parameter int          N_DIG          = 4,
  parameter logic [7:0]  SOF            = 8'h23,
  parameter logic [7:0]  OP_MIN         = 8'h01,
  parameter logic [7:0]  OP_MAX         = 8'h04,
  parameter int          TIMEOUT_CYCLES = 5_000_000,
  localparam int         AW             = N_DIG > 1 ? $clog2(N_DIG) : 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_finished,
  input  logic          i_cmd_ack,
  output logic          o_cmd_valid,
  output logic [7:0]    o_cmd_opcode,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic          o_frame_err,
  output logic          o_overrun,
  output logic [3:0]    o_db_estado
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_OPCODE   = 4'd1,
    S_DIGITS   = 4'd2,
    S_CHECK    = 4'd3,
    S_WAIT_ACK = 4'd4,
    S_ERROR    = 4'd5
  } state_t;
  state_t        r_state, w_nxt;
  logic [AW-1:0] r_idx, w_idx;
  logic [7:0]    r_chk, w_chk, r_op, w_op, w_cmd_op;
  logic [TW-1:0] r_tmo, w_tmo;
  logic          w_in_frame, w_tmo_hit, w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [7:0]    w_wr_data;
  always_comb begin
    w_nxt      = r_state;
    w_idx      = r_idx;
    w_chk      = r_chk;
    w_op       = r_op;
    w_cmd_op   = o_cmd_opcode;
    w_wr_en    = 1'b0;
    w_wr_addr  = '0;
    w_wr_data  = '0;
    w_in_frame = r_state == S_OPCODE || r_state == S_DIGITS || r_state == S_CHECK;
    // Inter-byte watchdog: restarts on every byte, stays clear outside a frame
    w_tmo_hit  = w_in_frame && !i_rx_finished && r_tmo == TW'(TIMEOUT_CYCLES - 1);
    w_tmo      = (w_in_frame && !i_rx_finished && !w_tmo_hit) ? r_tmo + 1'b1 : '0;
    case (r_state)
      S_IDLE:   w_nxt = (i_rx_finished && i_rx_data == SOF) ? S_OPCODE : S_IDLE;
      S_OPCODE: begin
        if (i_rx_finished) begin
          w_nxt = (i_rx_data >= OP_MIN && i_rx_data <= OP_MAX) ? S_DIGITS : S_ERROR;
          w_op  = i_rx_data;
          w_chk = i_rx_data;
          w_idx = '0;
        end else if (w_tmo_hit) w_nxt = S_ERROR;
      end
      S_DIGITS: begin
        if (i_rx_finished) begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_idx;
          w_wr_data = i_rx_data;
          w_chk     = r_chk ^ i_rx_data;
          w_idx     = r_idx + 1'b1;
          w_nxt     = r_idx == AW'(N_DIG - 1) ? S_CHECK : S_DIGITS;
        end else if (w_tmo_hit) w_nxt = S_ERROR;
      end
      S_CHECK: begin
        if (i_rx_finished) begin
          w_nxt    = i_rx_data == r_chk ? S_WAIT_ACK : S_ERROR;
          w_cmd_op = i_rx_data == r_chk ? r_op : o_cmd_opcode;
        end else if (w_tmo_hit) w_nxt = S_ERROR;
      end
      S_WAIT_ACK: w_nxt = i_cmd_ack ? S_IDLE : S_WAIT_ACK;
      default:    w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_chk        <= '0;
      r_op         <= '0;
      r_tmo        <= '0;
      o_cmd_valid  <= 1'b0;
      o_cmd_opcode <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_idx        <= w_idx;
      r_chk        <= w_chk;
      r_op         <= w_op;
      r_tmo        <= w_tmo;
      o_cmd_valid  <= w_nxt == S_WAIT_ACK;
      o_cmd_opcode <= w_cmd_op;
      o_wr_en      <= w_wr_en;
      o_wr_addr    <= w_wr_addr;
      o_wr_data    <= w_wr_data;
      o_frame_err  <= w_nxt == S_ERROR;
      // Bytes arriving while a command waits for ack are dropped and flagged
      o_overrun    <= r_state == S_WAIT_ACK && i_rx_finished;
    end
  end
  assign o_db_estado = r_state;
endmodule

// File: tb/tb_serial_cmd_sequencer.sv
// tb_serial_cmd_sequencer: table-driven frames with a scoreboard of expected writes, commands and pulses
module tb_serial_cmd_sequencer;
  localparam int N = 4, TMO = 100;
  localparam int K_OK = 0, K_ERRC = 1, K_ERRO = 2, K_IGN = 3;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_fin = 1'b0, ack = 1'b0;
  logic       o_cmd_valid, o_wr_en, o_frame_err, o_overrun;
  logic [7:0] o_cmd_opcode, o_wr_data;
  logic [1:0] o_wr_addr;
  logic [3:0] o_db_estado;
  always #5 clk = ~clk;
  serial_cmd_sequencer #(.N_DIG(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_finished(rx_fin), .i_cmd_ack(ack),
    .o_cmd_valid(o_cmd_valid), .o_cmd_opcode(o_cmd_opcode), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_db_estado(o_db_estado)
  );
  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    int              kind;
    int              hold;
    int              ov;
  } frame_t;
  frame_t     tbl[9];
  logic [9:0] wr_q[$];
  logic [7:0] cmd_q[$];
  int         n_chk = 0, n_pass = 0;
  int         err_exp = 0, err_seen = 0, ov_exp = 0, ov_seen = 0;
  logic       prev_valid = 1'b0, prev_err = 1'b0;
  logic [7:0] held = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (o_wr_en) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else chk("wr_addr_data", {22'd0, o_wr_addr, o_wr_data}, {22'd0, wr_q.pop_front()});
    end
    if (o_cmd_valid && !prev_valid) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
      else chk("cmd_opcode", o_cmd_opcode, cmd_q.pop_front());
    end
    if (o_cmd_valid && prev_valid) chk("opcode_stable", o_cmd_opcode, held);
    if (o_frame_err) begin
      chk("frame_err_expected", err_seen < err_exp, 1);
      chk("frame_err_single", prev_err, 0);
      err_seen++;
    end
    if (o_overrun) begin
      chk("overrun_expected", ov_seen < ov_exp, 1);
      ov_seen++;
    end
    held       = o_cmd_opcode;
    prev_valid = o_cmd_valid;
    prev_err   = o_frame_err;
  end
  task automatic send(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1 rx_data = b; rx_fin = 1'b1;
    @(posedge clk);
    #1 rx_fin = 1'b0;
  endtask
  task automatic chk_zero(input string name);
    chk(name, {o_cmd_valid, o_cmd_opcode, o_wr_en, o_wr_addr, o_wr_data, o_frame_err, o_overrun, o_db_estado}, 0);
  endtask
  task automatic do_ack(input int hold, input bit with_byte);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("valid_held", o_cmd_valid, 1);
    end
    @(posedge clk);
    #1 ack = 1'b1;
    if (with_byte) begin
      rx_data = 8'h55; rx_fin = 1'b1; ov_exp++;
    end
    @(posedge clk);
    #1 ack = 1'b0; rx_fin = 1'b0;
    chk("valid_drop", o_cmd_valid, 0);
    chk("estado_idle_after_ack", o_db_estado, 0);
  endtask
  task automatic run_frame(input frame_t f);
    if (f.kind == K_OK || f.kind == K_ERRC)
      for (int i = 0; i < N; i++) wr_q.push_back({2'(i), f.b[2+i]});
    if (f.kind == K_ERRC || f.kind == K_ERRO) err_exp++;
    if (f.kind == K_OK) cmd_q.push_back(f.b[1]);
    for (int i = 0; i < f.n; i++) send(f.b[i]);
    if (f.kind == K_OK) begin
      chk("valid_latency", o_cmd_valid, 1);
      chk("estado_wait_ack", o_db_estado, 4);
      if (f.ov == 2) begin
        @(posedge clk);
        #1 rx_data = 8'hAA; rx_fin = 1'b1; ov_exp++;
        @(posedge clk);
        #1 rx_fin = 1'b0;
        chk("valid_after_overrun", o_cmd_valid, 1);
        chk("estado_after_overrun", o_db_estado, 4);
      end
      do_ack(f.hold, f.ov == 1);
    end else begin
      if (f.kind != K_IGN) chk("frame_err_latency", o_frame_err, 1);
      if (f.kind != K_IGN) chk("estado_error", o_db_estado, 5);
      repeat (3) @(posedge clk);
      #1;
      chk("estado_idle", o_db_estado, 0);
      chk("no_valid", o_cmd_valid, 0);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    tbl[0] = '{64'h23_01_31_32_33_34_05_00, 7, K_OK,   10, 0};
    tbl[1] = '{64'h23_02_31_32_33_34_07_00, 7, K_ERRC, 0,  0};
    tbl[2] = '{64'h23_09_00_00_00_00_00_00, 2, K_ERRO, 0,  0};
    tbl[3] = '{64'h23_01_31_32_33_34_05_00, 7, K_OK,   2,  0};
    tbl[4] = '{64'h00_FF_41_00_00_00_00_00, 3, K_IGN,  0,  0};
    tbl[5] = '{64'h23_04_23_00_AA_55_D8_00, 7, K_OK,   1,  1};
    tbl[6] = '{64'h23_00_00_00_00_00_00_00, 2, K_ERRO, 0,  0};
    tbl[7] = '{64'h23_05_00_00_00_00_00_00, 2, K_ERRO, 0,  0};
    tbl[8] = '{64'h23_03_00_00_00_00_03_00, 7, K_OK,   0,  2};
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_outputs");
    rst = 1'b0;
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("ack_in_idle_ignored", {o_cmd_valid, o_db_estado}, 0);
    for (int i = 0; i < 9; i++) run_frame(tbl[i]);
    wr_q.push_back({2'd0, 8'h31});
    err_exp++;
    send(8'h23); send(8'h01); send(8'h31);
    k = 0;
    while (!o_frame_err && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_cycles", k, TMO);
    send(8'h41); send(8'h42);
    repeat (3) @(posedge clk);
    #1 chk("estado_after_timeout", o_db_estado, 0);
    wr_q.push_back({2'd0, 8'h31});
    wr_q.push_back({2'd1, 8'h32});
    send(8'h23); send(8'h01); send(8'h31); send(8'h32);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk_zero("reset_mid_frame");
    rst = 1'b0;
    repeat (TMO + 20) @(posedge clk);
    #1 chk("estado_after_reset", o_db_estado, 0);
    run_frame(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_empty", wr_q.size(), 0);
    chk("cmd_queue_empty", cmd_q.size(), 0);
    chk("frame_err_count", err_seen, err_exp);
    chk("overrun_count", ov_seen, ov_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
